// File: rtl/bram_sched_pkg.sv
// Shared types for the frame BRAM write-port scheduler.
package bram_sched_pkg;

    // The port is either handed out to stream/random writers or owned by the clear engine.
    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. req[0] is the stream and req[1] is the random writer.
// gnt is combinational from req. When both requesters are active, the one not served last wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // High when requester 1 should win the next tie. Reset favours the stream.
    logic pref_r;

    assign gnt[0] = req[0] & (~req[1] | ~pref_r);
    assign gnt[1] = req[1] & (~req[0] |  pref_r);

    // After a grant is accepted, hand the tie-break to the other requester.
    always_ff @(posedge clk) begin
        if (rst)
            pref_r <= 1'b0;
        else if (advance)
            pref_r <= gnt[0];
    end

endmodule

// File: rtl/bram_wr_sched.sv
// Write-port scheduler for the frame BRAM. It muxes the sensor stream (auto-incrementing
// address), random overlay/host writes and a whole-memory clear onto one registered write port.
module bram_wr_sched
    import bram_sched_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 256,
    localparam int ADDRW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_start,
    input  logic [WIDTH-1:0] clear_value,
    output logic             clear_busy,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic             frame_done,
    input  logic             r_valid,
    output logic             r_ready,
    input  logic [ADDRW-1:0] r_addr,
    input  logic [WIDTH-1:0] r_data,
    output logic             we,
    output logic [ADDRW-1:0] addr_write,
    output logic [WIDTH-1:0] data_in
);

    localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(DEPTH - 1);

    state_t           state;
    logic [ADDRW-1:0] s_addr;
    logic [ADDRW-1:0] clr_cnt;
    logic [1:0]       gnt;
    logic             grant_ok;
    logic             s_hs;
    logic             r_hs;
    logic             s_wrap;

    // Requesters may only be granted in RUN. A clear request in the same cycle takes priority.
    // Reset also masks the grants so that no ready is raised while rst is high.
    assign grant_ok = ~rst & (state == RUN) & ~clear_start;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({r_valid, s_valid} & {2{grant_ok}}),
        .advance (s_hs | r_hs),
        .gnt     (gnt)
    );

    // A grant is only raised for a valid requester, so a grant is a handshake.
    assign s_ready = gnt[0];
    assign r_ready = gnt[1];
    assign s_hs    = gnt[0];
    assign r_hs    = gnt[1];
    assign s_wrap  = s_last | (s_addr == LAST_ADDR);

    // Scheduler FSM. It owns the address counters and the registered BRAM write stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            s_addr     <= '0;
            clr_cnt    <= '0;
            clear_busy <= 1'b0;
            frame_done <= 1'b0;
            we         <= 1'b0;
            addr_write <= '0;
            data_in    <= '0;
        end else begin
            we         <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                RUN: begin
                    if (clear_start) begin
                        // Restart the frame so the first beat after the clear lands at 0.
                        state      <= CLEAR;
                        clear_busy <= 1'b1;
                        clr_cnt    <= '0;
                        s_addr     <= '0;
                    end else if (s_hs) begin
                        we         <= 1'b1;
                        addr_write <= s_addr;
                        data_in    <= s_data;
                        frame_done <= s_wrap;
                        s_addr     <= s_wrap ? '0 : s_addr + ADDRW'(1);
                    end else if (r_hs) begin
                        we         <= 1'b1;
                        addr_write <= r_addr;
                        data_in    <= r_data;
                    end
                end
                CLEAR: begin
                    // clear_value is sampled on each step, so a changing value is not latched.
                    we         <= 1'b1;
                    addr_write <= clr_cnt;
                    data_in    <= clear_value;
                    clr_cnt    <= clr_cnt + ADDRW'(1);
                    if (clr_cnt == LAST_ADDR) begin
                        state      <= RUN;
                        clear_busy <= 1'b0;
                        clr_cnt    <= '0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_wr_sched.sv
// Self-checking bench for bram_wr_sched with DEPTH = 8.
// A transaction-level model predicts the ready lines and the registered write port on
// every cycle. Directed scenarios then pin the resulting write log against literal values.
module tb_bram_wr_sched;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear_start = 1'b0;
    logic [W-1:0]  clear_value = '0;
    logic          clear_busy;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [W-1:0]  s_data = '0;
    logic          s_last = 1'b0;
    logic          frame_done;
    logic          r_valid = 1'b0;
    logic          r_ready;
    logic [AW-1:0] r_addr = '0;
    logic [W-1:0]  r_data = '0;
    logic          we;
    logic [AW-1:0] addr_write;
    logic [W-1:0]  data_in;

    always #5 clk = ~clk;

    bram_wr_sched #(.WIDTH(W), .DEPTH(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear_start (clear_start),
        .clear_value (clear_value),
        .clear_busy  (clear_busy),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .frame_done  (frame_done),
        .r_valid     (r_valid),
        .r_ready     (r_ready),
        .r_addr      (r_addr),
        .r_data      (r_data),
        .we          (we),
        .addr_write  (addr_write),
        .data_in     (data_in)
    );

    int tests = 0;
    int fails = 0;

    // Model state: clear in progress, next clear index, stream position, and tie-break owner.
    bit m_known = 0, m_busy = 0, m_pref_r = 0, m_gs = 0, m_gr = 0;
    int m_clr = 0, m_saddr = 0;
    // Expected registered outputs for the current cycle.
    bit e_we = 0, e_fd = 0, e_chk_ad = 0;
    int e_addr = 0, e_data = 0;

    typedef struct {
        int addr;
        int data;
        bit fd;
    } wr_t;
    wr_t log_q[$];
    int  busy_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: no handshake within bound at %0t", name, $time);
    endtask

    // Who the rules allow to be granted this cycle, given the current inputs.
    task automatic exp_grant(output bit gs, output bit gr);
        gs = 0;
        gr = 0;
        if (!(rst || m_busy || clear_start)) begin
            if (s_valid && r_valid) begin
                gs = !m_pref_r;
                gr = m_pref_r;
            end else begin
                gs = s_valid;
                gr = r_valid;
            end
        end
    endtask

    // Advance the model across one rising edge.
    task automatic model_update();
        bit gs, gr;
        exp_grant(gs, gr);
        m_gs = gs;
        m_gr = gr;
        e_we = 0;
        e_fd = 0;
        e_chk_ad = 0;
        if (rst) begin
            m_known = 1; m_busy = 0; m_pref_r = 0; m_clr = 0; m_saddr = 0;
            e_addr = 0; e_data = 0; e_chk_ad = 1;
        end else if (m_busy) begin
            e_we = 1; e_addr = m_clr; e_data = int'(clear_value);
            if (m_clr == D - 1) m_busy = 0;
            m_clr++;
        end else if (clear_start) begin
            m_busy = 1; m_clr = 0; m_saddr = 0;
        end else if (gs) begin
            e_we = 1; e_addr = m_saddr; e_data = int'(s_data);
            e_fd = s_last || (m_saddr == D - 1);
            m_saddr = e_fd ? 0 : m_saddr + 1;
            m_pref_r = 1;
        end else if (gr) begin
            e_we = 1; e_addr = int'(r_addr); e_data = int'(r_data);
            m_pref_r = 0;
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model, plus write logging.
    task automatic check();
        bit gs, gr;
        exp_grant(gs, gr);
        if (m_known) begin
            chk("s_ready", 32'(s_ready), 32'(gs));
            chk("r_ready", 32'(r_ready), 32'(gr));
            chk("we", 32'(we), 32'(e_we));
            chk("frame_done", 32'(frame_done), 32'(e_fd));
            chk("clear_busy", 32'(clear_busy), 32'(m_busy));
            if (e_we || e_chk_ad) begin
                chk("addr_write", 32'(addr_write), 32'(e_addr));
                chk("data_in", 32'(data_in), 32'(e_data));
            end
        end
        if (we === 1'b1) log_q.push_back('{int'(addr_write), int'(data_in), frame_done === 1'b1});
        if (clear_busy === 1'b1) busy_cnt++;
    endtask

    // Inputs are driven at the falling edge. Outputs are checked 1 ns later,
    // and the model advances on the rising edge.
    task automatic cycle();
        #1;
        check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic send_s(input logic [W-1:0] d, input bit last);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        do begin
            cycle();
            n++;
        end while (!m_gs && n < 50);
        if (!m_gs) timeout("stream_beat");
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic chk_log(input string name, input int idx, input int a, input int d, input bit fd);
        if (idx < log_q.size()) begin
            chk({name, "_addr"}, 32'(log_q[idx].addr), 32'(a));
            chk({name, "_data"}, 32'(log_q[idx].data), 32'(d));
            chk({name, "_fd"}, 32'(log_q[idx].fd), 32'(fd));
        end
    endtask

    initial begin
        int alt_a[6];
        int alt_d[6];
        int n;
        alt_a = '{0, 5, 1, 5, 2, 5};
        alt_d = '{8'h30, 8'h40, 8'h31, 8'h41, 8'h32, 8'h42};

        // Reset
        cycle();
        cycle();
        chk("reset_we", 32'(we), 32'd0);
        chk("reset_busy", 32'(clear_busy), 32'd0);
        chk("reset_addr", 32'(addr_write), 32'd0);
        chk("reset_data", 32'(data_in), 32'd0);
        chk("reset_fd", 32'(frame_done), 32'd0);
        rst = 1'b0;
        cycle();

        // Contending stream and random writers alternate S,R,S,R,S,R.
        log_q.delete();
        s_valid = 1'b1; r_valid = 1'b1; r_addr = 3'd5; s_data = 8'h30; r_data = 8'h40;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (m_gs) s_data = s_data + 8'd1;
            if (m_gr) r_data = r_data + 8'd1;
        end
        s_valid = 1'b0; r_valid = 1'b0;
        cycle();
        chk("alt_count", 32'(log_q.size()), 32'd6);
        for (int k = 0; k < 6; k++) chk_log("alt", k, alt_a[k], alt_d[k], 1'b0);

        // Clear collides with a stream beat. A second request during the clear is ignored.
        log_q.delete();
        busy_cnt = 0;
        clear_value = 8'hAA; clear_start = 1'b1;
        s_valid = 1'b1; s_data = 8'h55; s_last = 1'b0;
        cycle();
        chk("clr_no_hs_ready", 32'(log_q.size()), 32'd0);
        clear_start = 1'b0;
        cycle(); cycle(); cycle();
        clear_start = 1'b1;
        cycle();
        clear_start = 1'b0;
        n = 0;
        while (!m_gs && n < 30) begin cycle(); n++; end
        if (!m_gs) timeout("held_beat_after_clear");
        s_valid = 1'b0;
        cycle();
        chk("clr_busy_cycles", 32'(busy_cnt), 32'd8);
        chk("clr_count", 32'(log_q.size()), 32'd9);
        for (int k = 0; k < 8; k++) chk_log("clr", k, k, 8'hAA, 1'b0);
        chk_log("held_beat", 8, 0, 8'h55, 1'b0);

        // Short frame. 0x55 above was beat 1; 0x56 and 0x57 (last) complete it.
        log_q.delete();
        send_s(8'h56, 1'b0);
        send_s(8'h57, 1'b1);
        cycle();
        chk("short_count", 32'(log_q.size()), 32'd2);
        chk_log("short1", 0, 1, 8'h56, 1'b0);
        chk_log("short2", 1, 2, 8'h57, 1'b1);

        // Full 8-beat frame. The next beat starts again at address 0.
        log_q.delete();
        for (int k = 0; k < 8; k++) send_s(W'(8'h10 + k), k == 7);
        send_s(8'h20, 1'b0);
        cycle();
        chk("frame_count", 32'(log_q.size()), 32'd9);
        for (int k = 0; k < 8; k++) chk_log("frame", k, k, 8'h10 + k, k == 7);
        chk_log("frame_next", 8, 0, 8'h20, 1'b0);

        // Reset part-way through a clear.
        log_q.delete();
        clear_value = 8'h3C; clear_start = 1'b1;
        cycle();
        clear_start = 1'b0;
        n = 0;
        while (log_q.size() < 4 && n < 20) begin cycle(); n++; end
        if (log_q.size() < 4) timeout("clear_writes");
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rstclr_we", 32'(we), 32'd0);
        chk("rstclr_busy", 32'(clear_busy), 32'd0);
        send_s(8'h77, 1'b0);
        cycle();
        chk("rstclr_beat_addr", 32'(log_q[$].addr), 32'd0);
        chk("rstclr_beat_data", 32'(log_q[$].data), 32'h77);

        // Randomised traffic with occasional clears and resets. The model checks every cycle.
        for (int k = 0; k < 3000; k++) begin
            if (m_gs || !s_valid) begin
                s_valid = ($urandom % 4) != 0;
                s_data  = W'($urandom);
                s_last  = ($urandom % 6) == 0;
            end
            if (m_gr || !r_valid) begin
                r_valid = ($urandom % 3) != 0;
                r_data  = W'($urandom);
                r_addr  = AW'($urandom);
            end
            clear_start = ($urandom % 50) == 0;
            clear_value = W'($urandom);
            rst = ($urandom % 400) == 0;
            cycle();
        end
        s_valid = 1'b0; r_valid = 1'b0; clear_start = 1'b0; rst = 1'b0;
        cycle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
